// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/writeback sequencer.
// It owns the pc, the Z/N flag register, the memory handshakes and branch resolution.
// Optional memory-ack watchdog: define SEQ_WATCHDOG_EN.
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            instr_latch,
    input  logic            reg_write,
    input  logic            is_mem_access,
    input  logic            dm_write_enable,
    input  logic            flags_write,
    input  logic            is_jz,
    input  logic            is_jnz,
    input  logic            is_jl,
    input  logic            is_jg,
    input  logic            is_jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            alu_zero,
    input  logic            alu_neg,
    output logic            dmem_req,
    output logic            dm_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic            flag_z,
    output logic            flag_n,
    output logic [2:0]      state,
    output logic            busy,
    output logic            wdog_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_z_q, flag_z_d;
    logic            flag_n_q, flag_n_d;
    logic            taken_q, taken_d;
    logic            wdog_err_q, wdog_err_d;
    logic            wdog_fire;

`ifdef SEQ_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          waiting, ack_in;

    // Count unacknowledged wait cycles; the counter rests at zero outside FETCH/MEM so every entry starts fresh
    always_comb begin
        waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
        ack_in    = (state_q == S_FETCH) ? imem_ack : dmem_ack;
        wcnt_d    = (waiting && !ack_in) ? wcnt_q + CW'(1) : '0;
        wdog_fire = waiting && !ack_in && (wcnt_q == CW'(WDOG_CYCLES - 1));
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (!rst_n) wcnt_q <= '0;
        else        wcnt_q <= wcnt_d;
    end
`else
    // Without the watchdog a wait on an ack never aborts
    assign wdog_fire = (WDOG_CYCLES < 0);
`endif

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            taken_q    <= 1'b0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            taken_q    <= taken_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = wdog_fire ? S_HALT : (imem_ack ? S_DECODE : S_FETCH);
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_mem_access || dm_write_enable) ? S_MEM : S_WB;
            S_MEM:    state_d = wdog_fire ? S_HALT : (dmem_ack ? S_WB : S_MEM);
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Branch decision from stored flags, flag update at EXEC exit, pc advance at WB exit
    always_comb begin
        taken_d    = (state_q == S_EXEC)
                   ? (is_jump | (is_jz & flag_z_q) | (is_jnz & ~flag_z_q) | (is_jl & flag_n_q)
                      | (is_jg & ~flag_z_q & ~flag_n_q))
                   : taken_q;
        flag_z_d   = (state_q == S_EXEC && flags_write) ? alu_zero : flag_z_q;
        flag_n_d   = (state_q == S_EXEC && flags_write) ? alu_neg : flag_n_q;
        pc_d       = (state_q == S_WB) ? (taken_q ? jump_target : pc_q + PC_W'(1)) : pc_q;
        wdog_err_d = wdog_err_q | wdog_fire;
    end

    // Outputs decoded from the registered state
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        instr_latch = (state_q == S_FETCH) && imem_ack;
        dmem_req    = (state_q == S_MEM);
        dm_we       = (state_q == S_MEM) && dm_write_enable;
        rf_we       = (state_q == S_WB) && reg_write;
        busy        = (state_q != S_IDLE) && (state_q != S_HALT);
        pc          = pc_q;
        flag_z      = flag_z_q;
        flag_n      = flag_n_q;
        state       = state_q;
        wdog_err    = wdog_err_q;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the 5-bit-opcode CPU. It owns the program counter and the Z/N flag register, and steps each instruction through fetch, decode, execute, optional memory and writeback. It performs the request/acknowledge handshakes with instruction and data memory, and resolves jumps and conditional branches. The opcode decoder drives its control inputs; its outputs gate the register file, data memory and instruction register.

## Interface
- PC_W, 8: program counter width; jump_target width.
- WDOG_CYCLES, 16: cycles allowed waiting on a memory ack before abort (only with watchdog compiled in).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  level; high permits starting new instructions.
- pc  out  PC_W  current instruction address.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid.
- instr_latch  out  1  one-cycle pulse: load instruction register.
- reg_write, is_mem_access, dm_write_enable, flags_write  in  1 each  decoder controls, valid from DECODE through WB.
- is_jz, is_jnz, is_jl, is_jg, is_jump  in  1 each  decoder branch controls.
- jump_target  in  PC_W  branch/jump destination.
- alu_zero, alu_neg  in  1 each  ALU result flags, valid in EXEC.
- dmem_req  out  1  data memory request.
- dm_we  out  1  data memory write strobe; only ever high together with dmem_req.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register file write pulse.
- flag_z, flag_n  out  1 each  stored flags.
- state  out  3  FSM state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- busy  out  1  high in every state except IDLE and HALT.
- wdog_err  out  1  sticky watchdog abort flag.

## Operation
- Reset (rst_n low at an edge): state=IDLE, pc=0, flag_z=flag_n=0, wdog_err=0, all strobes/requests 0. Reset wins over every other event, including mid-handshake.
- IDLE:
  - run=1 → FETCH; otherwise stay.
- FETCH:
  - imem_req held high until imem_ack is sampled high.
  - On ack: instr_latch pulses that cycle, then → DECODE.
- DECODE: one cycle, → EXEC.
- EXEC: one cycle.
  - Branch taken = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z) | (is_jl & flag_n) | (is_jg & ~flag_z & ~flag_n).
  - Conditions use stored flags, not the current alu outputs. Taken decision is latched.
  - If flags_write: flag_z<=alu_zero, flag_n<=alu_neg at exit.
  - Next state: → MEM if is_mem_access | dm_write_enable, else → WB.
- MEM:
  - dmem_req high until dmem_ack sampled high.
  - dm_we = dm_write_enable for the whole MEM stay.
  - On ack → WB.
- WB: one cycle.
  - rf_we = reg_write.
  - pc <= taken ? jump_target : pc+1, modulo 2^PC_W (pc=2^PC_W−1 wraps to 0).
  - Next state: → FETCH if run=1, else → IDLE.
- run falling mid-instruction: the current instruction completes; the sequencer stops after WB.
- Opcode with all controls 0 (nop/unknown): FETCH→DECODE→EXEC→WB, pc+1, no strobes.
- HALT: reachable only via watchdog. All requests low, pc frozen. Exits only on reset.

## Timing
- Registered outputs; state, pc and flags change only on rising clk.
- imem_ack/dmem_ack are accepted in the same cycle the request is first asserted.
- Minimum latency with immediate acks: 4 cycles for non-memory instructions (FETCH, DECODE, EXEC, WB), 5 cycles for lw/sw.
- Each extra wait cycle on an ack adds one cycle.
- A new pc is visible the cycle FETCH is entered.
- flag_z/flag_n are visible from the cycle after EXEC.
- rf_we is exactly one cycle wide per writing instruction.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When the counter reaches WDOG_CYCLES: requests drop, wdog_err<=1, → HALT.
  - An ack arriving in the same cycle the count reaches the limit is accepted; the watchdog does not fire.
- SEQ_WATCHDOG_EN undefined: no counter; FETCH/MEM wait indefinitely; wdog_err tied 0; HALT unreachable.

## Test plan
- Reset with run=1, imem_ack always 1, add (reg_write, flags_write, alu_zero=1) → states 1,2,3,5; rf_we one pulse in cycle 4; pc 0→1; flag_z=1 afterwards.
- sw with dmem_ack delayed 3 cycles → dmem_req and dm_we high for 4 cycles, rf_we never high, total 8 cycles, pc+1.
- flag_z=1, then jz with jump_target=0x40 → pc=0x40. Repeat with flag_z=0 → pc+1. Also check jg with flag_n=0, flag_z=0 → taken.
- pc=0xFF, nop → pc wraps to 0x00. Deassert run during EXEC → WB completes, state=IDLE, busy=0.
- With SEQ_WATCHDOG_EN, WDOG_CYCLES=16, imem_ack held 0 → wdog_err=1, state=HALT after 16 FETCH cycles. Ack at cycle 16 → no error.
- Assert rst_n=0 during MEM with dmem_req high → next cycle state=IDLE, pc=0, dmem_req=0, flags=0.
